// File: rtl/stream_arb_pkg.sv
// Shared types for the round-robin spill arbiter.
package stream_arb_pkg;

   // Grant lock state: IDLE re-arbitrates each cycle, LOCKED pins the grant.
   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin priority select: first valid index at or after
// start_i, wrapping modulo NumIn.
module rr_prio_sel #(
   parameter int unsigned NumIn    = 4,
   parameter int unsigned IdxWidth = $clog2(NumIn)
) (
   input  logic [NumIn-1:0]    valid_i,
   input  logic [IdxWidth-1:0] start_i,
   output logic [IdxWidth-1:0] gnt_idx_o,
   output logic                gnt_valid_o
);

   // Scan from the farthest offset down so the nearest valid index wins.
   always_comb begin
      logic [IdxWidth:0] pos;
      pos         = '0;
      gnt_idx_o   = start_i;
      gnt_valid_o = |valid_i;
      for (int k = NumIn - 1; k >= 0; k--) begin
         pos = {1'b0, start_i} + (IdxWidth + 1)'(k);
         if (pos >= (IdxWidth + 1)'(NumIn)) pos = pos - (IdxWidth + 1)'(NumIn);
         if (valid_i[pos[IdxWidth-1:0]]) gnt_idx_o = pos[IdxWidth-1:0];
      end
   end

endmodule

// File: rtl/stream_rr_spill_arbiter.sv
// Round-robin merge of NumIn valid/ready streams through a two-entry spill
// buffer; upstream ready never depends on downstream ready.
module stream_rr_spill_arbiter
   import stream_arb_pkg::*;
#(
   parameter int unsigned NumIn    = 4,
   parameter type         T        = logic,
   parameter bit          LockIn   = 1'b1,
   parameter int unsigned IdxWidth = $clog2(NumIn)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumIn-1:0]    valid_i,
   output logic [NumIn-1:0]    ready_o,
   input  T     [NumIn-1:0]    data_i,
   output logic                valid_o,
   input  logic                ready_i,
   output T                    data_o,
   output logic [IdxWidth-1:0] idx_o
);

   typedef logic [IdxWidth-1:0] idx_t;
   typedef struct packed {
      T     data;
      idx_t idx;
   } beat_t;

   idx_t       rr_q, rr_d, lock_idx_q, lock_idx_d, sel_idx, gnt_idx;
   logic       sel_valid, buf_rdy, hs, a_drain, b_drain, b_fill;
   logic       a_full_q, b_full_q;
   beat_t      a_q, b_q;
   arb_state_e state_q, state_d;

   rr_prio_sel #(
      .NumIn    (NumIn),
      .IdxWidth (IdxWidth)
   ) u_sel (
      .valid_i     (valid_i),
      .start_i     (rr_q),
      .gnt_idx_o   (sel_idx),
      .gnt_valid_o (sel_valid)
   );

   // Ready only looks at registered full flags, which cuts ready_i -> ready_o.
   assign buf_rdy = !(a_full_q && b_full_q);
   assign gnt_idx = (state_q == ARB_LOCKED) ? lock_idx_q : sel_idx;

   // One-hot accept on the granted input whenever the buffer has room.
   always_comb begin
      ready_o = '0;
      if (buf_rdy && sel_valid) ready_o[gnt_idx] = 1'b1;
   end

   assign hs   = |(valid_i & ready_o);
   assign rr_d = (gnt_idx == idx_t'(NumIn - 1)) ? '0 : gnt_idx + idx_t'(1);

   // Lock next-state: pin the grant while a granted request waits on a full buffer.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (LockIn && sel_valid && !buf_rdy) begin
               state_d    = ARB_LOCKED;
               lock_idx_d = sel_idx;
            end
         end
         ARB_LOCKED: begin
            if (hs) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Lock state and pointer registers; pointer moves past each accepted input.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         lock_idx_q <= '0;
         rr_q       <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         if (hs) rr_q <= rr_d;
      end
   end

   // A empties whenever B is free: straight out if ready_i, else spilled into B.
   assign a_drain = a_full_q && !b_full_q;
   assign b_fill  = a_drain && !ready_i;
   assign b_drain = b_full_q && ready_i;

   // Spill buffer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         a_full_q <= hs | (a_full_q & ~a_drain);
         b_full_q <= b_fill | (b_full_q & ~b_drain);
         if (hs)     a_q <= '{data: data_i[gnt_idx], idx: gnt_idx};
         if (b_fill) b_q <= a_q;
      end
   end

   // B always holds the older beat, so it has output priority.
   assign valid_o = a_full_q | b_full_q;
   assign data_o  = b_full_q ? b_q.data : a_q.data;
   assign idx_o   = b_full_q ? b_q.idx : a_q.idx;

endmodule
